memory_s_sp_arbiter_2: RTL and testbench

Two-requester controller for a single-port synchronous SRAM macro with a 4096 x 8 organisation. Data reads back one cycle after the read strobe. After reset the block can sweep the whole array to zero. It then arbitrates per-cycle accesses from ports A and B round-robin and steers the returned read data back to the requester that issued the read. It sits between two client engines and one SRAM instance, and is the only driver of the SRAM control pins.

---
 rtl/memory_s_sp_arbiter_2_if.sv | 47 ++++
 rtl/memory_s_sp_arbiter_2.sv | 119 +++++++++++
 tb/tb_memory_s_sp_arbiter_2.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/memory_s_sp_arbiter_2_if.sv
// Bundle between the arbiter, its two client engines and the single-port SRAM.
// slave = arbiter view; master = clients plus the SRAM macro.
interface memory_s_sp_arbiter_2_if #(
  parameter int addr_width = 12,
  parameter int data_width = 8
);
  logic                  a_request;
  logic                  a_write;
  logic [addr_width-1:0] a_address;
  logic [data_width-1:0] a_write_data;
  logic                  a_ack;
  logic                  a_read_data_valid;

  logic                  b_request;
  logic                  b_write;
  logic [addr_width-1:0] b_address;
  logic [data_width-1:0] b_write_data;
  logic                  b_ack;
  logic                  b_read_data_valid;

  logic [data_width-1:0] read_data;
  logic                  init_done;

  logic                  sram_read;
  logic                  sram_write;
  logic [addr_width-1:0] sram_address;
  logic [data_width-1:0] sram_write_data;
  logic [data_width-1:0] sram_read_data;

  modport slave (
    input  a_request, a_write, a_address, a_write_data,
    input  b_request, b_write, b_address, b_write_data,
    input  sram_read_data,
    output a_ack, a_read_data_valid, b_ack, b_read_data_valid,
    output read_data, init_done,
    output sram_read, sram_write, sram_address, sram_write_data
  );

  modport master (
    output a_request, a_write, a_address, a_write_data,
    output b_request, b_write, b_address, b_write_data,
    output sram_read_data,
    input  a_ack, a_read_data_valid, b_ack, b_read_data_valid,
    input  read_data, init_done,
    input  sram_read, sram_write, sram_address, sram_write_data
  );
endinterface

// File: rtl/memory_s_sp_arbiter_2.sv
// Two-port round-robin front end for a single-port SRAM, with an optional
// post-reset zero fill. Read data returns one cycle after the read ack.
module memory_s_sp_arbiter_2 #(
  parameter int addr_width     = 12,
  parameter int data_width     = 8,
  parameter int clear_on_reset = 1
) (
  input  logic                     int_clock,
  input  logic                     int_reset,
  memory_s_sp_arbiter_2_if.slave   bus
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  localparam logic   PORT_A    = 1'b0;
  localparam logic   PORT_B    = 1'b1;
  localparam state_t RST_STATE = (clear_on_reset != 0) ? ST_CLEAR : ST_RUN;

  state_t                state_q, state_d;
  logic [addr_width-1:0] clear_count_q, clear_count_d;
  logic                  last_grant_q, last_grant_d;
  logic                  init_done_q, init_done_d;
  logic [1:0]            vld_q, vld_d;

  // Per-requester views, index 0 = A, 1 = B
  logic [1:0]                 req, wr, gnt;
  logic [1:0][addr_width-1:0] addr;
  logic [1:0][data_width-1:0] wdata;
  logic                       sel;

  logic                  sram_read_c, sram_write_c;
  logic [addr_width-1:0] sram_address_c;
  logic [data_width-1:0] sram_write_data_c;

  assign req   = {bus.b_request, bus.a_request};
  assign wr    = {bus.b_write, bus.a_write};
  assign addr  = {bus.b_address, bus.a_address};
  assign wdata = {bus.b_write_data, bus.a_write_data};

  always_comb begin
    state_d           = state_q;
    clear_count_d     = clear_count_q;
    last_grant_d      = last_grant_q;
    init_done_d       = init_done_q;
    gnt               = '0;
    sel               = PORT_A;
    sram_read_c       = 1'b0;
    sram_write_c      = 1'b0;
    sram_address_c    = addr[PORT_A];
    sram_write_data_c = wdata[PORT_A];

    case (state_q)
      ST_CLEAR: begin
        sram_write_c      = 1'b1;
        sram_address_c    = clear_count_q;
        sram_write_data_c = '0;
        clear_count_d     = clear_count_q + 1'b1;
        if (&clear_count_q) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        init_done_d = 1'b1;
        // Grants wait for init_done so the no-fill build still has one idle cycle
        if (init_done_q) begin
          if (req[PORT_A] && (!req[PORT_B] || last_grant_q == PORT_B))
            gnt[PORT_A] = 1'b1;
          else if (req[PORT_B])
            gnt[PORT_B] = 1'b1;
          sel = gnt[PORT_B];
          if (|gnt) begin
            last_grant_d      = sel;
            sram_write_c      = wr[sel];
            sram_read_c       = !wr[sel];
            sram_address_c    = addr[sel];
            sram_write_data_c = wdata[sel];
          end
        end
      end
    endcase

    if (int_reset) begin
      gnt          = '0;
      sram_read_c  = 1'b0;
      sram_write_c = 1'b0;
    end

    vld_d = gnt & ~wr;
  end

  always_ff @(posedge int_clock or posedge int_reset) begin
    if (int_reset) begin
      state_q       <= RST_STATE;
      clear_count_q <= '0;
      last_grant_q  <= PORT_B;
      init_done_q   <= 1'b0;
      vld_q         <= '0;
    end else begin
      state_q       <= state_d;
      clear_count_q <= clear_count_d;
      last_grant_q  <= last_grant_d;
      init_done_q   <= init_done_d;
      vld_q         <= vld_d;
    end
  end

  assign bus.a_ack             = gnt[PORT_A];
  assign bus.b_ack             = gnt[PORT_B];
  assign bus.a_read_data_valid = vld_q[PORT_A];
  assign bus.b_read_data_valid = vld_q[PORT_B];
  assign bus.read_data         = bus.sram_read_data;
  assign bus.init_done         = init_done_q;
  assign bus.sram_read         = sram_read_c;
  assign bus.sram_write        = sram_write_c;
  assign bus.sram_address      = sram_address_c;
  assign bus.sram_write_data   = sram_write_data_c;

endmodule

// File: tb/tb_memory_s_sp_arbiter_2.sv
// Bench: table-driven sequences on a no-fill instance, then fill, randomized
// traffic against a reference model, and mid-operation reset on a fill instance.
module tb_memory_s_sp_arbiter_2;

  logic int_clock = 1'b0;
  logic rst1, rst0;
  always #5 int_clock = ~int_clock;

  memory_s_sp_arbiter_2_if #(.addr_width(12), .data_width(8)) bus1 ();
  memory_s_sp_arbiter_2_if #(.addr_width(12), .data_width(8)) bus0 ();

  memory_s_sp_arbiter_2 #(.addr_width(12), .data_width(8), .clear_on_reset(1)) u_dut1 (
    .int_clock(int_clock), .int_reset(rst1), .bus(bus1));
  memory_s_sp_arbiter_2 #(.addr_width(12), .data_width(8), .clear_on_reset(0)) u_dut0 (
    .int_clock(int_clock), .int_reset(rst0), .bus(bus0));

  // SRAM macro models
  logic [7:0] mem1 [4096];
  logic [7:0] mem0 [4096];
  logic [7:0] rd1, rd0;
  always @(posedge int_clock) begin
    if (bus1.sram_write) mem1[bus1.sram_address] <= bus1.sram_write_data;
    if (bus1.sram_read)  rd1 <= mem1[bus1.sram_address];
    if (bus0.sram_write) mem0[bus0.sram_address] <= bus0.sram_write_data;
    if (bus0.sram_read)  rd0 <= mem0[bus0.sram_address];
  end
  assign bus1.sram_read_data = rd1;
  assign bus0.sram_read_data = rd0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       a_req, a_wr; logic [11:0] a_addr; logic [7:0] a_wd;
    logic       b_req, b_wr; logic [11:0] b_addr; logic [7:0] b_wd;
    logic       e_init, e_a, e_b, e_va, e_vb; logic [7:0] e_rd;
  } vec_t;

  vec_t tbl [20];

  // Reference model state for the randomized phase
  logic [7:0] ref_mem [4096];
  logic       ap, bp, ga, gb, last_b, exp_va, exp_vb;
  logic [7:0] exp_rd;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //           rst a_req wr addr    wd      b_req wr addr    wd     init a  b  va vb rd
    tbl[0]  = '{1'b1, 1,1,12'h123,8'h5A,  0,0,12'h000,8'h00,  0,0,0,0,0,8'h00};
    tbl[1]  = '{1'b0, 1,1,12'h123,8'h5A,  0,0,12'h000,8'h00,  0,0,0,0,0,8'h00};
    tbl[2]  = '{1'b0, 1,1,12'h123,8'h5A,  0,0,12'h000,8'h00,  1,1,0,0,0,8'h00};
    tbl[3]  = '{1'b0, 1,0,12'h123,8'h00,  0,0,12'h000,8'h00,  1,1,0,0,0,8'h00};
    tbl[4]  = '{1'b0, 0,0,12'h000,8'h00,  0,0,12'h000,8'h00,  1,0,0,1,0,8'h5A};
    tbl[5]  = '{1'b0, 1,1,12'h001,8'h11,  1,1,12'h002,8'h22,  1,0,1,0,0,8'h00};
    tbl[6]  = '{1'b0, 1,1,12'h001,8'h11,  0,0,12'h000,8'h00,  1,1,0,0,0,8'h00};
    tbl[7]  = '{1'b1, 0,0,12'h000,8'h00,  0,0,12'h000,8'h00,  0,0,0,0,0,8'h00};
    tbl[8]  = '{1'b0, 1,0,12'h001,8'h00,  1,0,12'h002,8'h00,  0,0,0,0,0,8'h00};
    tbl[9]  = '{1'b0, 1,0,12'h001,8'h00,  1,0,12'h002,8'h00,  1,1,0,0,0,8'h00};
    tbl[10] = '{1'b0, 1,0,12'h001,8'h00,  1,0,12'h002,8'h00,  1,0,1,1,0,8'h11};
    tbl[11] = '{1'b0, 1,0,12'h001,8'h00,  1,0,12'h002,8'h00,  1,1,0,0,1,8'h22};
    tbl[12] = '{1'b0, 1,0,12'h001,8'h00,  1,0,12'h002,8'h00,  1,0,1,1,0,8'h11};
    tbl[13] = '{1'b0, 0,0,12'h000,8'h00,  0,0,12'h000,8'h00,  1,0,0,0,1,8'h22};
    tbl[14] = '{1'b0, 0,0,12'h000,8'h00,  1,0,12'h002,8'h00,  1,0,1,0,0,8'h00};
    tbl[15] = '{1'b0, 0,0,12'h000,8'h00,  1,0,12'h002,8'h00,  1,0,1,0,1,8'h22};
    tbl[16] = '{1'b0, 0,0,12'h000,8'h00,  1,0,12'h002,8'h00,  1,0,1,0,1,8'h22};
    tbl[17] = '{1'b0, 1,0,12'h001,8'h00,  1,0,12'h002,8'h00,  1,1,0,0,1,8'h22};
    tbl[18] = '{1'b0, 0,0,12'h000,8'h00,  1,0,12'h002,8'h00,  1,0,1,1,0,8'h11};
    tbl[19] = '{1'b0, 0,0,12'h000,8'h00,  0,0,12'h000,8'h00,  1,0,0,0,1,8'h22};

    rst0 = 1'b1; rst1 = 1'b1;
    bus0.a_request = 0; bus0.a_write = 0; bus0.a_address = '0; bus0.a_write_data = '0;
    bus0.b_request = 0; bus0.b_write = 0; bus0.b_address = '0; bus0.b_write_data = '0;
    bus1.a_request = 0; bus1.a_write = 0; bus1.a_address = '0; bus1.a_write_data = '0;
    bus1.b_request = 0; bus1.b_write = 0; bus1.b_address = '0; bus1.b_write_data = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    repeat (2) @(posedge int_clock);
    #1;

    chk("rst_init_done", bus1.init_done, 0);
    chk("rst_a_valid", bus1.a_read_data_valid, 0);
    chk("rst_b_valid", bus1.b_read_data_valid, 0);
    chk("rst_sram_write", bus1.sram_write, 0);
    chk("rst_sram_read", bus1.sram_read, 0);

    // Table sequences on the no-fill instance
    for (int r = 0; r < 20; r++) begin
      logic       ew, er;
      logic [11:0] ea;
      rst0 = tbl[r].rst;
      bus0.a_request = tbl[r].a_req; bus0.a_write = tbl[r].a_wr;
      bus0.a_address = tbl[r].a_addr; bus0.a_write_data = tbl[r].a_wd;
      bus0.b_request = tbl[r].b_req; bus0.b_write = tbl[r].b_wr;
      bus0.b_address = tbl[r].b_addr; bus0.b_write_data = tbl[r].b_wd;
      @(negedge int_clock);
      ew = (tbl[r].e_a & tbl[r].a_wr) | (tbl[r].e_b & tbl[r].b_wr);
      er = (tbl[r].e_a & !tbl[r].a_wr) | (tbl[r].e_b & !tbl[r].b_wr);
      ea = tbl[r].e_b ? tbl[r].b_addr : tbl[r].a_addr;
      chk($sformatf("tbl%0d_init", r), bus0.init_done, tbl[r].e_init);
      chk($sformatf("tbl%0d_a_ack", r), bus0.a_ack, tbl[r].e_a);
      chk($sformatf("tbl%0d_b_ack", r), bus0.b_ack, tbl[r].e_b);
      chk($sformatf("tbl%0d_a_vld", r), bus0.a_read_data_valid, tbl[r].e_va);
      chk($sformatf("tbl%0d_b_vld", r), bus0.b_read_data_valid, tbl[r].e_vb);
      chk($sformatf("tbl%0d_sram_wr", r), bus0.sram_write, ew);
      chk($sformatf("tbl%0d_sram_rd", r), bus0.sram_read, er);
      if (tbl[r].e_a | tbl[r].e_b)
        chk($sformatf("tbl%0d_sram_addr", r), bus0.sram_address, ea);
      if (tbl[r].e_va | tbl[r].e_vb)
        chk($sformatf("tbl%0d_rdata", r), bus0.read_data, tbl[r].e_rd);
      @(posedge int_clock);
      #1;
    end

    // Zero fill with A holding a write request throughout
    bus1.a_request = 1; bus1.a_write = 1; bus1.a_address = 12'h7F3; bus1.a_write_data = 8'hC3;
    rst1 = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      @(negedge int_clock);
      chk("fill_write", bus1.sram_write, 1);
      chk("fill_read", bus1.sram_read, 0);
      chk("fill_addr", bus1.sram_address, i);
      chk("fill_data", bus1.sram_write_data, 0);
      chk("fill_a_ack", bus1.a_ack, 0);
      chk("fill_init", bus1.init_done, 0);
      @(posedge int_clock);
      #1;
    end

    // Randomized traffic; A's held fill-time write is the first pending request
    ap = 1; bp = 0; last_b = 1; exp_va = 0; exp_vb = 0; exp_rd = '0;
    for (int c = 0; c < 2000; c++) begin
      if (!ap) begin
        ap = ($urandom_range(0, 9) < 6);
        bus1.a_request = ap; bus1.a_write = 1'($urandom_range(0, 1));
        bus1.a_address = 12'($urandom_range(0, 15)); bus1.a_write_data = 8'($urandom);
      end
      if (!bp) begin
        bp = ($urandom_range(0, 9) < 6);
        bus1.b_request = bp; bus1.b_write = 1'($urandom_range(0, 1));
        bus1.b_address = 12'($urandom_range(0, 15)); bus1.b_write_data = 8'($urandom);
      end
      @(negedge int_clock);
      ga = ap && (!bp || last_b);
      gb = bp && !ga;
      chk("rnd_init", bus1.init_done, 1);
      chk("rnd_a_ack", bus1.a_ack, ga);
      chk("rnd_b_ack", bus1.b_ack, gb);
      chk("rnd_a_vld", bus1.a_read_data_valid, exp_va);
      chk("rnd_b_vld", bus1.b_read_data_valid, exp_vb);
      if (exp_va | exp_vb) chk("rnd_rdata", bus1.read_data, exp_rd);
      if (ga) begin
        chk("rnd_wr_a", bus1.sram_write, bus1.a_write);
        chk("rnd_rd_a", bus1.sram_read, !bus1.a_write);
        chk("rnd_addr_a", bus1.sram_address, bus1.a_address);
        if (bus1.a_write) begin
          chk("rnd_wd_a", bus1.sram_write_data, bus1.a_write_data);
          ref_mem[bus1.a_address] = bus1.a_write_data;
        end else exp_rd = ref_mem[bus1.a_address];
        last_b = 0; ap = 0;
      end else if (gb) begin
        chk("rnd_wr_b", bus1.sram_write, bus1.b_write);
        chk("rnd_rd_b", bus1.sram_read, !bus1.b_write);
        chk("rnd_addr_b", bus1.sram_address, bus1.b_address);
        if (bus1.b_write) begin
          chk("rnd_wd_b", bus1.sram_write_data, bus1.b_write_data);
          ref_mem[bus1.b_address] = bus1.b_write_data;
        end else exp_rd = ref_mem[bus1.b_address];
        last_b = 1; bp = 0;
      end else begin
        chk("rnd_idle_wr", bus1.sram_write, 0);
        chk("rnd_idle_rd", bus1.sram_read, 0);
      end
      exp_va = ga && !bus1.a_write;
      exp_vb = gb && !bus1.b_write;
      @(posedge int_clock);
      #1;
    end

    // Reset pulsed in the cycle after an A read ack
    bus1.a_request = 0; bus1.b_request = 0;
    repeat (2) @(posedge int_clock);
    #1;
    bus1.a_request = 1; bus1.a_write = 0; bus1.a_address = 12'h005;
    @(negedge int_clock);
    chk("rr_a_ack", bus1.a_ack, 1);
    @(posedge int_clock);
    #1;
    bus1.a_request = 0;
    chk("rr_vld_before", bus1.a_read_data_valid, 1);
    rst1 = 1'b1;
    #1;
    chk("rr_vld_dropped", bus1.a_read_data_valid, 0);
    chk("rr_init_low", bus1.init_done, 0);
    chk("rr_sram_wr_forced", bus1.sram_write, 0);
    @(posedge int_clock);
    #1;
    rst1 = 1'b0;
    @(negedge int_clock);
    chk("rr_clear_wr", bus1.sram_write, 1);
    chk("rr_clear_addr0", bus1.sram_address, 0);
    chk("rr_clear_init", bus1.init_done, 0);
    @(posedge int_clock);
    #1;
    @(negedge int_clock);
    chk("rr_clear_addr1", bus1.sram_address, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
